// File: rtl/xheep_jtag_master_pkg.sv
// ============================================================================
// Package : xheep_jtag_master_pkg
// Brief   : Shared types and TMS walk patterns for the x-heep JTAG initiator.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package xheep_jtag_master_pkg;

    // Command opcodes as presented on cmd_op_i
    typedef enum logic [1:0] {
        OP_RESET    = 2'd0,
        OP_SHIFT_IR = 2'd1,
        OP_SHIFT_DR = 2'd2,
        OP_IDLE     = 2'd3
    } op_e;

    // Sequencer states; every scan starts and ends in Run-Test/Idle
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TMS_PRE  = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_TMS_POST = 3'd3,
        ST_RSP      = 3'd4
    } state_e;

    localparam int PAT_W = 6;

    // TMS patterns are LSB-first: bit 0 is driven on the first TCK
    // Test-Logic-Reset from anywhere, then drop into Run-Test/Idle
    localparam logic [PAT_W-1:0] TMS_PRE_RESET     = 6'b011111;
    localparam logic [2:0]       TMS_PRE_RESET_LEN = 3'd6;
    // RTI -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [PAT_W-1:0] TMS_PRE_IR        = 6'b000011;
    localparam logic [2:0]       TMS_PRE_IR_LEN    = 3'd4;
    // RTI -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [PAT_W-1:0] TMS_PRE_DR        = 6'b000001;
    localparam logic [2:0]       TMS_PRE_DR_LEN    = 3'd3;
    // Exit1 -> Update -> Run-Test/Idle
    localparam logic [PAT_W-1:0] TMS_POST          = 6'b000001;
    localparam logic [2:0]       TMS_POST_LEN      = 3'd2;

endpackage

`default_nettype wire

// File: rtl/xheep_jtag_tck_gen.sv
// ============================================================================
// Module  : xheep_jtag_tck_gen
// Brief   : Divides clk_gen into TCK; low phase first after enable, with
//           single-cycle strobes flagging the edges that will move tck_o.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module xheep_jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_gen,
    input  logic rst_n,
    input  logic en_i,
    output logic tck_o,
    output logic fall_tick_o,
    output logic rise_tick_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tck_q;
    logic             tck_d;
    logic             wrap;

    // Phase boundary: the coming clk_gen edge toggles tck
    assign wrap        = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
    assign rise_tick_o = wrap && !tck_q;
    assign fall_tick_o = wrap && tck_q;
    assign tck_o       = tck_q;

    // Next phase counter / tck level; disabling parks TCK low at phase start
    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!en_i) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            tck_d = ~tck_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Divider state register
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/xheep_jtag_master.sv
// ============================================================================
// Module  : xheep_jtag_master
// Brief   : Command-driven JTAG initiator for the x-heep debug TAP. Turns
//           RESET / SHIFT_IR / SHIFT_DR / IDLE commands into TCK/TMS/TDI
//           sequences and returns the captured TDO bits.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module xheep_jtag_master
    import xheep_jtag_master_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int LEN_W   = $clog2(DATA_W + 1),
    parameter int CLK_DIV = 4
) (
    input  logic              clk_gen,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    output logic              trst_no,
    input  logic              tdo_i
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [2:0]        pcnt_q, pcnt_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic              trst_q, trst_d;
    logic              init_q, init_d;

    op_e               cmd_op;
    logic              accept;
    logic [LEN_W-1:0]  len_eff;
    logic [PAT_W-1:0]  pre_pat;
    logic [2:0]        pre_len;
    logic              tck_en;
    logic              fall_tick;
    logic              rise_tick;

    assign cmd_op      = op_e'(cmd_op_i);
    assign accept      = (state_q == ST_IDLE) && init_q && cmd_valid_i;
    assign cmd_ready_o = (state_q == ST_IDLE) && init_q;
    assign rsp_valid_o = (state_q == ST_RSP);
    assign busy_o      = (state_q != ST_IDLE);
    assign rsp_data_o  = rsp_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;
    assign trst_no     = trst_q;
    assign tck_en      = (state_q == ST_TMS_PRE) || (state_q == ST_SHIFT) ||
                         (state_q == ST_TMS_POST);

    xheep_jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk_gen     (clk_gen),
        .rst_n       (rst_n),
        .en_i        (tck_en),
        .tck_o       (tck_o),
        .fall_tick_o (fall_tick),
        .rise_tick_o (rise_tick)
    );

    // Effective length: scans run at least one bit and never beyond DATA_W
    always_comb begin
        len_eff = cmd_len_i;
        if (cmd_op != OP_IDLE) begin
            if (cmd_len_i == '0) begin
                len_eff = LEN_W'(1);
            end else if (cmd_len_i > LEN_W'(DATA_W)) begin
                len_eff = LEN_W'(DATA_W);
            end
        end
    end

    // Entry TMS walk selected by the incoming opcode
    always_comb begin
        pre_pat = TMS_PRE_DR;
        pre_len = TMS_PRE_DR_LEN;
        case (cmd_op)
            OP_RESET: begin
                pre_pat = TMS_PRE_RESET;
                pre_len = TMS_PRE_RESET_LEN;
            end
            OP_SHIFT_IR: begin
                pre_pat = TMS_PRE_IR;
                pre_len = TMS_PRE_IR_LEN;
            end
            default: begin
                pre_pat = TMS_PRE_DR;
                pre_len = TMS_PRE_DR_LEN;
            end
        endcase
    end

    // Sequencer next state: TMS/TDI move on TCK falls, TDO captured on rises
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        pcnt_d  = pcnt_q;
        sreg_d  = sreg_q;
        rsp_d   = rsp_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        trst_d  = trst_q;
        init_d  = 1'b1;

        // TRST is released on the first clock out of reset
        if (!init_q) begin
            trst_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op;
                    len_d  = len_eff;
                    cnt_d  = '0;
                    rsp_d  = '0;
                    tdi_d  = 1'b0;
                    if (cmd_op == OP_IDLE) begin
                        sreg_d  = '0;
                        tms_d   = 1'b0;
                        state_d = (cmd_len_i == '0) ? ST_RSP : ST_SHIFT;
                    end else begin
                        sreg_d  = (cmd_op == OP_RESET) ? '0 : cmd_data_i;
                        tms_d   = pre_pat[0];
                        pat_d   = pre_pat >> 1;
                        pcnt_d  = pre_len - 3'd1;
                        state_d = ST_TMS_PRE;
                        if (cmd_op == OP_RESET) begin
                            trst_d = 1'b0;
                        end
                    end
                end
            end

            ST_TMS_PRE: begin
                if (fall_tick) begin
                    if (pcnt_q != 3'd0) begin
                        tms_d  = pat_q[0];
                        pat_d  = pat_q >> 1;
                        pcnt_d = pcnt_q - 3'd1;
                        // TRST covers the first five TCKs of a TAP reset
                        if ((op_q == OP_RESET) && (pcnt_q == 3'd1)) begin
                            trst_d = 1'b1;
                        end
                    end else if (op_q == OP_RESET) begin
                        state_d = ST_RSP;
                    end else begin
                        cnt_d   = '0;
                        tms_d   = (len_q == LEN_W'(1));
                        tdi_d   = sreg_q[0];
                        sreg_d  = sreg_q >> 1;
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                if (rise_tick && (op_q != OP_IDLE)) begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (cnt_q == LEN_W'(i)) begin
                            rsp_d[i] = tdo_i;
                        end
                    end
                end
                if (fall_tick) begin
                    if (cnt_q == (len_q - LEN_W'(1))) begin
                        tdi_d = 1'b0;
                        if (op_q == OP_IDLE) begin
                            state_d = ST_RSP;
                        end else begin
                            tms_d   = TMS_POST[0];
                            pat_d   = TMS_POST >> 1;
                            pcnt_d  = TMS_POST_LEN - 3'd1;
                            state_d = ST_TMS_POST;
                        end
                    end else begin
                        cnt_d  = cnt_q + LEN_W'(1);
                        tdi_d  = sreg_q[0];
                        sreg_d = sreg_q >> 1;
                        tms_d  = (op_q != OP_IDLE) &&
                                 ((cnt_q + LEN_W'(1)) == (len_q - LEN_W'(1)));
                    end
                end
            end

            ST_TMS_POST: begin
                if (fall_tick) begin
                    if (pcnt_q != 3'd0) begin
                        tms_d  = pat_q[0];
                        pat_d  = pat_q >> 1;
                        pcnt_d = pcnt_q - 3'd1;
                    end else begin
                        state_d = ST_RSP;
                    end
                end
            end

            ST_RSP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and datapath registers
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_RESET;
            len_q   <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            pcnt_q  <= '0;
            sreg_q  <= '0;
            rsp_q   <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            trst_q  <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            pcnt_q  <= pcnt_d;
            sreg_q  <= sreg_d;
            rsp_q   <= rsp_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            trst_q  <= trst_d;
            init_q  <= init_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xheep_jtag_master.sv
// ============================================================================
// Module  : tb_xheep_jtag_master
// Brief   : Self-checking bench with a behavioural JTAG TAP (5-bit IR,
//           IDCODE 0x1000_1C05, bypass otherwise) and a response scoreboard.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_xheep_jtag_master;

    localparam int DATA_W  = 64;
    localparam int LEN_W   = $clog2(DATA_W + 1);
    localparam int CLK_DIV = 4;
    localparam logic [31:0] IDCODE = 32'h1000_1C05;

    logic              clk_gen = 1'b0;
    logic              rst_n   = 1'b0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic [1:0]        cmd_op_i = 2'd0;
    logic [LEN_W-1:0]  cmd_len_i = '0;
    logic [DATA_W-1:0] cmd_data_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [DATA_W-1:0] rsp_data_o;
    logic              busy_o;
    logic              tck_o, tms_o, tdi_o, trst_no;
    logic              tdo_i = 1'b0;

    xheep_jtag_master #(
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk_gen     (clk_gen),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_data_i  (cmd_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .busy_o      (busy_o),
        .tck_o       (tck_o),
        .tms_o       (tms_o),
        .tdi_o       (tdi_o),
        .trst_no     (trst_no),
        .tdo_i       (tdo_i)
    );

    always #5 clk_gen = ~clk_gen;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- TCK edge recorder ----------------
    int           tck_cnt = 0;
    logic [127:0] tms_bits, tdi_bits, trst_bits;
    time          rise_t0, rise_t1;

    always @(posedge tck_o) begin
        if (tck_cnt < 128) begin
            tms_bits[tck_cnt]  = tms_o;
            tdi_bits[tck_cnt]  = tdi_o;
            trst_bits[tck_cnt] = trst_no;
        end
        if (tck_cnt == 0) rise_t0 = $time;
        if (tck_cnt == 1) rise_t1 = $time;
        tck_cnt++;
    end

    // ---------------- Behavioural TAP ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
    } tap_e;

    tap_e        tap_st   = TLR;
    logic [4:0]  tap_ir   = 5'h01;
    logic [4:0]  tap_irsh = 5'h00;
    logic [31:0] tap_dr   = 32'h0;
    logic        tap_bp   = 1'b0;

    function automatic tap_e tap_next(input tap_e s, input logic tms);
        case (s)
            TLR:   return tms ? TLR   : RTI;
            RTI:   return tms ? SELDR : RTI;
            SELDR: return tms ? SELIR : CAPDR;
            CAPDR: return tms ? EX1DR : SHDR;
            SHDR:  return tms ? EX1DR : SHDR;
            EX1DR: return tms ? UPDR  : PADR;
            PADR:  return tms ? EX2DR : PADR;
            EX2DR: return tms ? UPDR  : SHDR;
            UPDR:  return tms ? SELDR : RTI;
            SELIR: return tms ? TLR   : CAPIR;
            CAPIR: return tms ? EX1IR : SHIR;
            SHIR:  return tms ? EX1IR : SHIR;
            EX1IR: return tms ? UPIR  : PAIR;
            PAIR:  return tms ? EX2IR : PAIR;
            EX2IR: return tms ? UPIR  : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck_o or negedge trst_no) begin
        if (!trst_no) begin
            tap_st = TLR;
            tap_ir = 5'h01;
        end else begin
            case (tap_st)
                TLR:   tap_ir = 5'h01;
                CAPDR: begin tap_dr = IDCODE; tap_bp = 1'b0; end
                SHDR:  begin tap_dr = {tdi_o, tap_dr[31:1]}; tap_bp = tdi_o; end
                CAPIR: tap_irsh = 5'h01;
                SHIR:  tap_irsh = {tdi_o, tap_irsh[4:1]};
                UPIR:  tap_ir = tap_irsh;
                default: ;
            endcase
            tap_st = tap_next(tap_st, tms_o);
        end
    end

    always @(negedge tck_o or negedge trst_no) begin
        if (!trst_no) tdo_i = 1'b0;
        else if (tap_st == SHDR) tdo_i = (tap_ir == 5'h01) ? tap_dr[0] : tap_bp;
        else if (tap_st == SHIR) tdo_i = tap_irsh[0];
        else tdo_i = 1'b0;
    end

    // ---------------- Scoreboard ----------------
    logic [63:0] exp_q[$];

    task automatic send_cmd(input logic [1:0] op, input int len,
                            input logic [63:0] data, input logic [63:0] exp);
        int n;
        @(negedge clk_gen);
        tck_cnt = 0;
        exp_q.push_back(exp);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_len_i   = LEN_W'(len);
        cmd_data_i  = data;
        n = 0;
        while (!cmd_ready_o && n < 1000) begin
            @(negedge clk_gen);
            n++;
        end
        if (n >= 1000) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk_gen);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic get_rsp(input string tag);
        int n;
        logic [63:0] e;
        @(negedge clk_gen);
        rsp_ready_i = 1'b1;
        n = 0;
        while (!rsp_valid_o && n < 5000) begin
            @(negedge clk_gen);
            n++;
        end
        if (n >= 5000) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, rsp_data_o, e);
        end
        @(posedge clk_gen);
        #1;
        rsp_ready_i = 1'b0;
    endtask

    // ---------------- Stimulus ----------------
    initial begin : main
        logic [63:0] snap;
        int          n;
        int          snap_tck;

        repeat (3) @(negedge clk_gen);
        check("reset_outs", {57'd0, tck_o, tms_o, tdi_o, trst_no, cmd_ready_o, rsp_valid_o, busy_o},
              64'b0100000);
        check("reset_rsp_data", rsp_data_o, 64'd0);
        rst_n = 1'b1;
        #1;
        check("pre_first_clk", {62'd0, trst_no, cmd_ready_o}, 64'd0);
        @(posedge clk_gen);
        #1;
        check("first_clk", {62'd0, trst_no, cmd_ready_o}, 64'b11);

        // TAP reset
        send_cmd(2'd0, 0, 64'd0, 64'd0);
        get_rsp("reset_rsp");
        check("reset_tck_cnt", 64'(tck_cnt), 64'd6);
        check("reset_tms", {58'd0, tms_bits[5:0]}, 64'h1F);
        check("reset_trst", {58'd0, trst_bits[5:0]}, 64'h20);
        check("tck_period", 64'(rise_t1 - rise_t0), 64'd80);

        // IR scan
        send_cmd(2'd1, 5, 64'h11, 64'h1);
        get_rsp("ir_rsp");
        check("ir_tck_cnt", 64'(tck_cnt), 64'd11);
        check("ir_tms", {53'd0, tms_bits[10:0]}, 64'h303);
        check("ir_tdi", {53'd0, tdi_bits[10:0]}, 64'h110);
        check("ir_model", {59'd0, tap_ir}, 64'h11);

        // IDCODE read
        send_cmd(2'd0, 0, 64'd0, 64'd0);
        get_rsp("reset2_rsp");
        send_cmd(2'd2, 32, 64'd0, {32'd0, IDCODE});
        get_rsp("idcode");
        check("dr32_tck_cnt", 64'(tck_cnt), 64'd37);

        // Back-pressure
        send_cmd(2'd2, 32, 64'hDEAD_BEEF, {32'd0, IDCODE});
        n = 0;
        while (!rsp_valid_o && n < 5000) begin
            @(negedge clk_gen);
            n++;
        end
        snap     = rsp_data_o;
        snap_tck = tck_cnt;
        for (int i = 0; i < 20; i++) begin
            check("bp_flags", {61'd0, rsp_valid_o, cmd_ready_o, tck_o}, 64'b100);
            check("bp_data", rsp_data_o, snap);
            @(negedge clk_gen);
        end
        check("bp_no_tck", 64'(tck_cnt - snap_tck), 64'd0);
        get_rsp("bp_rsp");

        // IDLE len=0: response straight after accept
        send_cmd(2'd3, 0, 64'd0, 64'd0);
        check("idle0_valid", {63'd0, rsp_valid_o}, 64'd1);
        check("idle0_tck", 64'(tck_cnt), 64'd0);
        get_rsp("idle0_rsp");

        // IDLE len=3
        send_cmd(2'd3, 3, 64'hFF, 64'd0);
        get_rsp("idle3_rsp");
        check("idle3_tck", 64'(tck_cnt), 64'd3);
        check("idle3_tms_tdi", {58'd0, tms_bits[2:0], tdi_bits[2:0]}, 64'd0);

        // DR len=0 behaves as one bit
        send_cmd(2'd2, 0, 64'd0, 64'd1);
        get_rsp("dr0_rsp");
        check("dr0_tck", 64'(tck_cnt), 64'd6);

        // DR len=100 clamps to 64
        send_cmd(2'd2, 100, 64'h0123_4567_89AB_CDEF, {32'h89AB_CDEF, IDCODE});
        get_rsp("dr100_rsp");
        check("dr100_tck", 64'(tck_cnt), 64'd69);

        // Reset in the middle of a DR scan
        send_cmd(2'd2, 32, 64'd0, {32'd0, IDCODE});
        n = 0;
        while (tck_cnt < 14 && n < 2000) begin
            @(negedge clk_gen);
            n++;
        end
        check("midrst_reached", 64'(tck_cnt >= 14), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {57'd0, tck_o, tms_o, tdi_o, trst_no, cmd_ready_o, rsp_valid_o, busy_o},
              64'b0100000);
        check("midrst_rsp_data", rsp_data_o, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_gen);
        rst_n = 1'b1;
        send_cmd(2'd0, 0, 64'd0, 64'd0);
        get_rsp("post_rst_reset");
        send_cmd(2'd2, 32, 64'd0, {32'd0, IDCODE});
        get_rsp("post_rst_idcode");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
